// File: rtl/led_blinker_pkg.sv
// LED sequencer shared types.
// Holds the FSM state encoding used by led_blinker.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_on   = 2'd1,
    e_off  = 2'd2
  } led_blink_state_e;

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter that times one LED phase.
// Ports: clk_i, reset_n_i, ld_i/ld_val_i load, dec_i count, zero_o at 0.
module blink_timer #(
  parameter int unsigned cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   ld_i,
  input  logic [cnt_width_p-1:0] ld_val_i,
  input  logic                   dec_i,
  output logic                   zero_o
);

  logic [cnt_width_p-1:0] r_cnt;

  // Holds at zero rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (ld_i) begin
      r_cnt <= ld_val_i;
    end else if (dec_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/led_blinker.sv
// LED blink sequencer with one-deep request buffer.
// Ports: clk_i, reset_n_i, v_i/blinks_i/ready_o, led_o, busy_o, done_o.
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int unsigned on_cycles_p      = 50000,
  parameter int unsigned off_cycles_p     = 50000,
  parameter int unsigned cnt_width_p      = 16,
  parameter int unsigned blink_width_p    = 4,
  parameter bit          led_active_low_p = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [blink_width_p-1:0] blinks_i,
  output logic                     ready_o,
  output logic                     led_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam logic [cnt_width_p-1:0] ON_LD =
    cnt_width_p'(on_cycles_p - 1);
  localparam logic [cnt_width_p-1:0] OFF_LD =
    cnt_width_p'(off_cycles_p - 1);

  led_blink_state_e r_state;
  led_blink_state_e w_state_n;

  logic [blink_width_p-1:0] r_rem;
  logic [blink_width_p-1:0] w_rem_n;
  logic [blink_width_p-1:0] w_rem_dec;
  logic                     r_pend_v;
  logic                     w_pend_v_n;
  logic [blink_width_p-1:0] r_pend_b;
  logic [blink_width_p-1:0] w_pend_b_n;
  logic                     r_done;
  logic                     w_done_n;
  logic                     r_led;

  logic                     w_accept;
  logic                     w_bound;
  logic                     w_src_v;
  logic [blink_width_p-1:0] w_src_b;
  logic                     w_ld;
  logic [cnt_width_p-1:0]   w_ld_val;
  logic                     w_dec;
  logic                     w_zero;

  blink_timer #(
    .cnt_width_p(cnt_width_p)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .ld_i     (w_ld),
    .ld_val_i (w_ld_val),
    .dec_i    (w_dec),
    .zero_o   (w_zero)
  );

  assign w_accept  = v_i & ~r_pend_v;
  assign w_rem_dec = r_rem - 1'b1;

  always_comb begin
    w_state_n  = r_state;
    w_rem_n    = r_rem;
    w_pend_v_n = r_pend_v;
    w_pend_b_n = r_pend_b;
    w_done_n   = 1'b0;
    w_bound    = 1'b0;
    w_src_v    = 1'b0;
    w_src_b    = '0;
    w_ld       = 1'b0;
    w_ld_val   = '0;
    w_dec      = 1'b0;

    unique case (r_state)
      e_idle: begin
        w_bound = 1'b1;
      end
      e_on: begin
        if (w_zero) begin
          w_state_n = e_off;
          w_ld      = 1'b1;
          w_ld_val  = OFF_LD;
        end else begin
          w_dec = 1'b1;
        end
      end
      e_off: begin
        if (w_zero) begin
          if (w_rem_dec == '0) begin
            w_bound  = 1'b1;
            w_done_n = 1'b1;
          end else begin
            w_rem_n   = w_rem_dec;
            w_state_n = e_on;
            w_ld      = 1'b1;
            w_ld_val  = ON_LD;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_state_n = e_idle;
      end
    endcase

    // Sequence boundary: pending entry first, then a fresh input.
    if (w_bound) begin
      w_src_v = r_pend_v | w_accept;
      w_src_b = r_pend_v ? r_pend_b : blinks_i;
      w_pend_v_n = 1'b0;
      w_state_n  = e_idle;
      if (w_src_v) begin
        if (w_src_b == '0) begin
          w_done_n = 1'b1;
        end else begin
          w_state_n = e_on;
          w_ld      = 1'b1;
          w_ld_val  = ON_LD;
          w_rem_n   = w_src_b;
        end
      end
    end else if (w_accept) begin
      w_pend_v_n = 1'b1;
      w_pend_b_n = blinks_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= e_idle;
      r_rem    <= '0;
      r_pend_v <= 1'b0;
      r_pend_b <= '0;
      r_done   <= 1'b0;
      r_led    <= led_active_low_p;
    end else begin
      r_state  <= w_state_n;
      r_rem    <= w_rem_n;
      r_pend_v <= w_pend_v_n;
      r_pend_b <= w_pend_b_n;
      r_done   <= w_done_n;
      r_led    <= (w_state_n == e_on) ^ led_active_low_p;
    end
  end

  assign ready_o = ~r_pend_v;
  assign busy_o  = (r_state != e_idle);
  assign done_o  = r_done;
  assign led_o   = r_led;

endmodule

// File: tb/tb_led_blinker.sv
// Self-checking bench for led_blinker (on=3, off=2).
// Two DUTs share stimulus: active-high and active-low LED pin.
module tb_led_blinker;

  localparam int ON = 3;
  localparam int OFF = 2;
  localparam int P = ON + OFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v;
  logic [3:0] blinks;
  logic       ready_o, led_o, busy_o, done_o;
  logic       a_ready, a_led, a_busy, a_done;

  int vecs = 0;
  int misc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int lit_cnt = 0;

  always #5 clk = ~clk;

  led_blinker #(
    .on_cycles_p(ON), .off_cycles_p(OFF),
    .cnt_width_p(16), .blink_width_p(4),
    .led_active_low_p(1'b0)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v),
    .blinks_i(blinks), .ready_o(ready_o),
    .led_o(led_o), .busy_o(busy_o), .done_o(done_o)
  );

  led_blinker #(
    .on_cycles_p(ON), .off_cycles_p(OFF),
    .cnt_width_p(16), .blink_width_p(4),
    .led_active_low_p(1'b1)
  ) dut_al (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v),
    .blinks_i(blinks), .ready_o(a_ready),
    .led_o(a_led), .busy_o(a_busy), .done_o(a_done)
  );

  // Model: a running sequence is (n blinks, cycle index t);
  // lit iff t mod (on+off) < on. Requests wait in a queue.
  bit   m_seen = 0;
  bit   m_active = 0;
  bit   m_done = 0;
  int   m_n = 0;
  int   m_t = 0;
  int   m_pend[$];

  initial forever begin
    bit acc, fin, have;
    int src;
    @(posedge clk);
    if (!rst_n) begin
      m_active = 0;
      m_done = 0;
      m_t = 0;
      m_pend.delete();
    end else begin
      acc = v && (m_pend.size() == 0);
      fin = m_active && (m_t == m_n * P - 1);
      m_done = fin;
      if (!m_active || fin) begin
        have = 0;
        src = 0;
        if (m_pend.size() != 0) begin
          src = m_pend.pop_front();
          have = 1;
        end else if (acc) begin
          src = int'(blinks);
          have = 1;
        end
        m_active = 0;
        if (have) begin
          if (src == 0) m_done = 1;
          else begin
            m_active = 1;
            m_n = src;
            m_t = 0;
          end
        end
      end else begin
        m_t++;
        if (acc) m_pend.push_back(int'(blinks));
      end
    end
    m_seen = 1;
  end

  initial forever begin
    logic e_led, e_busy, e_done, e_ready;
    @(negedge clk);
    if (m_seen) begin
      e_led = m_active && ((m_t % P) < ON);
      e_busy = m_active;
      e_done = m_done;
      e_ready = (m_pend.size() == 0);
      vecs++;
      if (led_o !== e_led || busy_o !== e_busy ||
          done_o !== e_done || ready_o !== e_ready ||
          a_led !== ~e_led || a_busy !== e_busy ||
          a_done !== e_done || a_ready !== e_ready) begin
        misc++;
        $display("FAIL cycle@%0t led/busy/done/ready got %b%b%b%b al_led %b, want %b%b%b%b al_led %b",
          $time, led_o, busy_o, done_o, ready_o, a_led,
          e_led, e_busy, e_done, e_ready, ~e_led);
      end
      done_cnt += int'(done_o);
      busy_cnt += int'(busy_o);
      lit_cnt += int'(led_o);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      misc++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the handshake edge.
  task automatic send(input logic [3:0] n);
    bit ok;
    int budget;
    v = 1'b1;
    blinks = n;
    budget = 200;
    do begin
      ok = ready_o;
      @(posedge clk);
      #2;
      budget--;
    end while (!ok && budget > 0);
    if (!ok) begin
      misc++;
      $display("FAIL send_timeout: got ready 0 want 1");
    end
    v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [9:0] pat;
    int snap_d, snap_b, snap_l;
    pat = 10'b1110011100;
    rst_n = 1'b0;
    v = 1'b0;
    blinks = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_led", int'(led_o), 0);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_al_led", int'(a_led), 1);
    rst_n = 1'b1;
    idle(6);

    // Single N=2 sequence.
    send(4'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("single_led%0d", i), int'(led_o), int'(pat[9-i]));
    end
    @(negedge clk);
    chk("single_done", int'(done_o), 1);
    chk("single_busy", int'(busy_o), 0);
    @(negedge clk);
    chk("single_done_end", int'(done_o), 0);
    idle(3);

    // Chaining N=2 then N=1.
    send(4'd2);
    send(4'd1);
    @(negedge clk);
    chk("chain_ready", int'(ready_o), 0);
    repeat (9) @(negedge clk);
    chk("chain_led", int'(led_o), 1);
    chk("chain_done", int'(done_o), 1);
    idle(10);

    // Zero request.
    send(4'd0);
    @(negedge clk);
    chk("zero_done", int'(done_o), 1);
    chk("zero_led", int'(led_o), 0);
    chk("zero_busy", int'(busy_o), 0);
    @(negedge clk);
    chk("zero_done_end", int'(done_o), 0);
    idle(3);

    // Boundary collision: N=3 offered in final OFF with N=1 pending.
    send(4'd1);
    send(4'd1);
    idle(3);
    send(4'd3);
    idle(1);
    snap_d = done_cnt;
    idle(40);
    chk("collide_dones", done_cnt - snap_d, 2);
    chk("collide_idle", int'(busy_o), 0);

    // Max request honoured exactly.
    snap_l = lit_cnt;
    send(4'd15);
    idle(15 * P + 4);
    chk("max_lit", lit_cnt - snap_l, 15 * ON);

    // Reset mid-sequence during ON with pending held.
    send(4'd2);
    send(4'd1);
    chk("mid_on", int'(led_o), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("mrst_led", int'(led_o), 0);
    chk("mrst_busy", int'(busy_o), 0);
    chk("mrst_done", int'(done_o), 0);
    chk("mrst_ready", int'(ready_o), 1);
    chk("mrst_al_led", int'(a_led), 1);
    snap_d = done_cnt;
    snap_b = busy_cnt;
    idle(10);
    chk("mrst_no_done", done_cnt - snap_d, 0);
    chk("mrst_pend_drop", busy_cnt - snap_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/led_blinker.md
# led_blinker

Output-side LED sequencer: the pin-driving counterpart to the board's push-button debouncer. Accepts blink-count requests over a valid/ready handshake, holds one pending request, and drives a board LED pin through exact on/off phases so events are visible to a human. Sits next to the debouncer in the board top level, typically fed by debounced press events or debug status.

## Interface
- `on_cycles_p`, default 16'd50000: LED-asserted cycles per blink; legal range 1..2^cnt_width_p-1.
- `off_cycles_p`, default 16'd50000: LED-deasserted cycles per blink; legal range 1..2^cnt_width_p-1.
- `cnt_width_p`, default 16: phase timer width.
- `blink_width_p`, default 4: width of the blink-count field.
- `led_active_low_p`, default 0: 1 = pin driven low when lit.
- `clk_i  in  1`: single clock; all logic on posedge.
- `reset_n_i  in  1`: reset, synchronous, active-low.
- `v_i  in  1`: request valid.
- `blinks_i  in  blink_width_p`: number of blinks; 0 = no-op.
- `ready_o  out  1`: request accepted when `v_i & ready_o`.
- `led_o  out  1`: registered LED pin drive.
- `busy_o  out  1`: sequence active (state != IDLE).
- `done_o  out  1`: one-cycle pulse, request retired.

## Operation
- FSM states: IDLE, ON, OFF. State, timer, remaining count, and pending buffer are registers.
- Pending buffer: one entry (`pend_v`, `pend_blinks`). `ready_o = ~pend_v`; ready may be high in any state.
- Acceptance while no sequence starts this cycle writes the pending buffer. Stall (`v_i & ~ready_o`) has no effect; the requester holds.
- Next-request source at each sequence boundary (IDLE, or the last cycle of the final OFF): the pending entry if `pend_v`, else the accepted input this cycle, else none. The pending entry always wins, and an input accepted in the same cycle goes into the freed pending slot. No bubble between back-to-back sequences.
- Start with N>0: go to ON, timer loads `on_cycles_p-1`, remaining loads N.
- Start with N=0: stay or return to IDLE, no LED activity, `done_o` pulses next cycle.
- ON: LED lit. Timer counts down; at 0 go to OFF and load `off_cycles_p-1`.
- OFF: LED dark. At timer 0, decrement remaining. If remaining reaches 0, retire: `done_o` pulses next cycle and the next-source rule applies. Otherwise go to ON and reload.
- `led_o` is the registered function of next-state ON, XOR `led_active_low_p`. It is glitch-free with no combinational path to the pin.
- Width rules: the timer is an unsigned cnt_width_p down-counter and never wraps. Remaining is blink_width_p wide; the max request `2^blink_width_p-1` is honored exactly.

## Timing
- Reset (`reset_n_i` low at posedge): state IDLE, `pend_v`=0, timer 0, `ready_o`=1, `busy_o`=0, `done_o`=0, `led_o`=`led_active_low_p` (dark). Reset mid-sequence aborts immediately: no done pulse, and the pending entry is dropped.
- Handshake at edge k from IDLE with N>0: `led_o` lit and `busy_o`=1 from cycle k+1.
- Each blink is exactly `on_cycles_p` lit cycles followed by `off_cycles_p` dark cycles.
- Sequence length is N*(on+off) cycles. `done_o` is high in the first cycle after the final OFF cycle, coincident with the first lit cycle of a chained sequence.
- `ready_o` depends only on registered state, with no combinational path from `v_i`.

## Structure
- Package `led_blinker_pkg`: state enum `led_blink_state_e` {e_idle, e_on, e_off}.
- Sub-module `blink_timer`: loadable cnt_width_p down-counter with load value, load strobe, and `zero_o`. The FSM owns everything else.

## Test plan
- Reset defaults: hold `reset_n_i` low for 3 cycles -> `led_o`=0, `ready_o`=1, `busy_o`=0, `done_o`=0 (`led_active_low_p`=0).
- Single sequence, on=3, off=2: accept N=2 at edge 10 -> `led_o` pattern 1,1,1,0,0,1,1,1,0,0 over cycles 11-20; `done_o` high only in cycle 21; `busy_o` low at 21.
- Chaining: while N=2 runs, accept N=1 -> it lands in pending and `ready_o`=0 until it starts. Cycle 21 is lit, with `done_o`=1 in the same cycle.
- Zero request: accept N=0 in IDLE -> `done_o` pulses next cycle; `led_o` and `busy_o` stay 0.
- Boundary collision: pending holds N=1; in the final OFF cycle, offer N=3 with `v_i`=1 -> pending N=1 starts, N=3 is captured into pending, and the two sequences run back to back with 2 done pulses total.
- Reset mid-sequence: assert reset during an ON cycle -> next cycle `led_o`=0, state IDLE, no `done_o`, and pending cleared. Also check `led_active_low_p`=1 inverts all observed `led_o` values.
